// File: rtl/and8_serial_unit.sv
// Bit-serial bitwise AND engine with valid/ready handshakes, one result bit per clock LSB-first.
// Optional early exit when either operand runs out of ones: AND8_SERIAL_EARLY_EXIT_EN.
module and8_serial_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_bit;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    s_sh_d   = s_sh_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    last_bit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          s_sh_d  = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Result bits enter at the MSB, so after WIDTH shifts bit i sits at position i.
        s_sh_d   = {a_sh_q[0] & b_sh_q[0], s_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        last_bit = (cnt_q == CntW'(WIDTH - 1));
`ifdef AND8_SERIAL_EARLY_EXIT_EN
        if (last_bit || (a_sh_d == '0) || (b_sh_d == '0)) begin
          state_d = StDone;
          // Only cnt_q+1 bits were shifted in; right-align them, upper bits become zero.
          s_d     = s_sh_d >> (CntW'(WIDTH - 1) - cnt_q);
        end
`else
        if (last_bit) begin
          state_d = StDone;
          s_d     = s_sh_d;
        end
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign S         = s_q;

endmodule

// File: tb/tb_and8_serial_unit.sv
// Scoreboard bench for and8_serial_unit: driver pushes expected results, monitor pops on handshake.
module tb_and8_serial_unit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         busy;

  and8_serial_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    int           k;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;  // 0: out_ready high, 1: random stalls, 2: out_ready low

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else                    out_ready = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of SHIFT cycles: in early-exit mode, the first k at which either operand, shifted
  // right by k, has no ones left; otherwise always the full width.
  function automatic int exp_k(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef AND8_SERIAL_EARLY_EXIT_EN
    for (int k = 1; k <= int'(W); k++) begin
      if (((a >> k) == '0) || ((b >> k) == '0)) return k;
    end
`endif
    return int'(W);
  endfunction

  // Present a pair until accepted; returns 1 ns after the accept edge with in_valid low.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    int t  = 0;
    exp_t e;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = a & b;
        e.k = exp_k(a, b);
        e.acc = cyc;
        q.push_back(e);
        ok = 1'b1;
      end
      t++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares S on each output handshake, plus latency and hold-while-stalled.
  initial begin
    logic         ov_prev = 1'b0;
    logic         or_prev = 1'b0;
    logic [W-1:0] s_prev  = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!ov_prev) begin
          if (q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
          else check("latency", cyc - q[0].acc - 1, q[0].k);
        end else if (!or_prev) begin
          check("S_hold", S, s_prev);
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_result", S, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("S", S, e.s);
          end
        end
      end
      ov_prev = rst_n && out_valid;
      or_prev = out_ready;
      s_prev  = S;
    end
  end

  initial begin
    int t;
    rst_n    = 1'b0;
    in_valid = 1'b1;  // ignored during reset
    A        = 8'hFF;
    B        = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_S", S, 0);
    check("rst_in_ready_rel", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic
    send(8'hF0, 8'h3C);
    drain();

    // Backpressure
    rdy_mode = 2;
    send(8'hFF, 8'hA5);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_S", S, 8'hA5);
      check("bp_in_ready", in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Busy rejection: second pair held throughout SHIFT
    send(8'h0F, 8'hFF);
    send(8'hFF, 8'hFF);
    drain();

    // Reset mid-operation after 4 SHIFT cycles
    send(8'hFF, 8'hFF);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_S", S, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    check("midrst_still_idle", busy, 0);
    @(posedge clk);
    #1;

    // Early-exit candidates (full latency when the macro is off)
    send(8'h03, 8'hFF);
    drain();
    send(8'h00, 8'h5A);
    drain();

    // Random pairs with random stalls; shifts bias operands toward early zero-out
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(W'($urandom) >> $urandom_range(0, W), W'($urandom) >> $urandom_range(0, W));
    end
    drain();
    rdy_mode = 0;
    check("final_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
